// File: rtl/reflet_vga_term_pkg.sv
// Shared constants, state encoding and geometry helpers for the VGA text terminal.
// Geometry functions keep the cell-grid size and counter widths derived in one place.
package reflet_vga_term_pkg;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_DEL   = 8'h7F;

  typedef enum logic [1:0] {
    CLR_SCREEN,
    CLR_LINE,
    IDLE
  } term_state_t;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADVANCE,
    CUR_NEWLINE,
    CUR_BACK,
    CUR_HOME,
    CUR_RETURN
  } cur_cmd_t;

  function automatic int calc_cols(input int h_size, input int bit_reduction);
    return (h_size >> bit_reduction) / 8;
  endfunction

  function automatic int calc_rows(input int v_size, input int bit_reduction);
    return (v_size >> bit_reduction) / 8;
  endfunction

  function automatic int calc_hw(input int h_size, input int bit_reduction);
    return $clog2(h_size / 8) - bit_reduction;
  endfunction

  function automatic int calc_vw(input int v_size, input int bit_reduction);
    return $clog2(v_size / 8) - bit_reduction;
  endfunction

endpackage

// File: rtl/reflet_vga_term_cursor.sv
// Column/row counter over the text grid; used both as the clear-fill walker and the cursor.
// Wraps at the last column into the next row and from the last row back to row 0.
module reflet_vga_term_cursor
  import reflet_vga_term_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int HW   = 7,
  parameter int VW   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  cur_cmd_t      cmd,
  output logic [HW-1:0] col,
  output logic [VW-1:0] row,
  output logic          col_last,
  output logic          row_last
);

  localparam logic [HW-1:0] COL_MAX = HW'(COLS - 1);
  localparam logic [VW-1:0] ROW_MAX = VW'(ROWS - 1);
  localparam logic [HW-1:0] COL_ONE = HW'(1);
  localparam logic [VW-1:0] ROW_ONE = VW'(1);

  assign col_last = (col == COL_MAX);
  assign row_last = (row == ROW_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      case (cmd)
        CUR_ADVANCE: begin
          if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + ROW_ONE;
          end else begin
            col <= col + COL_ONE;
          end
        end
        CUR_NEWLINE: begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_ONE;
        end
        CUR_BACK:   if (col != '0) col <= col - COL_ONE;
        CUR_HOME: begin
          col <= '0;
          row <= '0;
        end
        CUR_RETURN: col <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/reflet_vga_term.sv
// Byte-stream terminal front end: interprets control codes, tracks a cursor and
// issues one-cycle cell writes to the text-mode renderer, clearing lines/screen as needed.
module reflet_vga_term
  import reflet_vga_term_pkg::*;
#(
  parameter int h_size        = 640,
  parameter int v_size        = 480,
  parameter int color_depth   = 8,
  parameter int bit_reduction = 0,
  localparam int COLS = calc_cols(h_size, bit_reduction),
  localparam int ROWS = calc_rows(v_size, bit_reduction),
  localparam int HW   = calc_hw(h_size, bit_reduction),
  localparam int VW   = calc_vw(v_size, bit_reduction)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   char_valid,
  output logic                   char_ready,
  input  logic [7:0]             char_data,
  input  logic [color_depth-1:0] R_fg_in,
  input  logic [color_depth-1:0] G_fg_in,
  input  logic [color_depth-1:0] B_fg_in,
  input  logic [color_depth-1:0] R_bg_in,
  input  logic [color_depth-1:0] G_bg_in,
  input  logic [color_depth-1:0] B_bg_in,
  output logic                   write_en,
  output logic [HW-1:0]          h_txt_out,
  output logic [VW-1:0]          v_txt_out,
  output logic [7:0]             char_out,
  output logic [color_depth-1:0] R_fg_out,
  output logic [color_depth-1:0] G_fg_out,
  output logic [color_depth-1:0] B_fg_out,
  output logic [color_depth-1:0] R_bg_out,
  output logic [color_depth-1:0] G_bg_out,
  output logic [color_depth-1:0] B_bg_out,
  output logic [HW-1:0]          cursor_h,
  output logic [VW-1:0]          cursor_v,
  output logic                   busy
);

  localparam int CW = 3 * color_depth;
  localparam logic [HW-1:0] COL_ONE = HW'(1);

  term_state_t   state, next_state;
  cur_cmd_t      fill_cmd, cur_cmd;
  logic [HW-1:0] fill_col, wr_col;
  logic [VW-1:0] fill_row, wr_row;
  logic          fill_col_last, fill_row_last, cur_col_last, cur_row_last_unused;
  logic          accept, wr_en, wr_from_in;
  logic [7:0]    wr_char;
  logic [CW-1:0] fg_in, bg_in, fg_q, bg_q, fg_out_q, bg_out_q;

  assign fg_in = {R_fg_in, G_fg_in, B_fg_in};
  assign bg_in = {R_bg_in, G_bg_in, B_bg_in};
  assign {R_fg_out, G_fg_out, B_fg_out} = fg_out_q;
  assign {R_bg_out, G_bg_out, B_bg_out} = bg_out_q;

  assign char_ready = (state == IDLE) && !reset;
  assign busy       = (state != IDLE);
  assign accept     = char_valid && char_ready;

  reflet_vga_term_cursor #(.COLS(COLS), .ROWS(ROWS), .HW(HW), .VW(VW)) u_fill (
    .clk(clk), .reset(reset), .cmd(fill_cmd),
    .col(fill_col), .row(fill_row), .col_last(fill_col_last), .row_last(fill_row_last)
  );

  reflet_vga_term_cursor #(.COLS(COLS), .ROWS(ROWS), .HW(HW), .VW(VW)) u_cursor (
    .clk(clk), .reset(reset), .cmd(cur_cmd),
    .col(cursor_h), .row(cursor_v), .col_last(cur_col_last), .row_last(cur_row_last_unused)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value held and no latch is inferred.
  always_comb begin
    next_state = state;
    fill_cmd   = CUR_HOLD;
    cur_cmd    = CUR_HOLD;
    wr_en      = 1'b0;
    wr_col     = fill_col;
    wr_row     = fill_row;
    wr_char    = CHAR_SPACE;
    wr_from_in = 1'b0;
    case (state)
      CLR_SCREEN: begin
        wr_en = 1'b1;
        if (fill_col_last && fill_row_last) begin
          next_state = IDLE;
          fill_cmd   = CUR_HOME;
        end else begin
          fill_cmd = CUR_ADVANCE;
        end
      end
      CLR_LINE: begin
        wr_en  = 1'b1;
        wr_row = cursor_v;
        // Home instead of advancing past the last column keeps the walker parked at (0,0).
        if (fill_col_last) begin
          next_state = IDLE;
          fill_cmd   = CUR_HOME;
        end else begin
          fill_cmd = CUR_ADVANCE;
        end
      end
      IDLE: begin
        if (accept) begin
          wr_from_in = 1'b1;
          wr_col     = cursor_h;
          wr_row     = cursor_v;
          case (char_data)
            CHAR_CR: cur_cmd = CUR_RETURN;
            CHAR_LF: begin
              cur_cmd    = CUR_NEWLINE;
              next_state = CLR_LINE;
            end
            CHAR_BS: begin
              if (cursor_h != '0) begin
                cur_cmd = CUR_BACK;
                wr_en   = 1'b1;
                wr_col  = cursor_h - COL_ONE;
              end
            end
            CHAR_FF: begin
              cur_cmd    = CUR_HOME;
              next_state = CLR_SCREEN;
            end
            default: begin
              if (char_data >= CHAR_SPACE && char_data != CHAR_DEL) begin
                wr_en   = 1'b1;
                wr_char = char_data;
                cur_cmd = CUR_ADVANCE;
                if (cur_col_last) next_state = CLR_LINE;
              end
            end
          endcase
        end
      end
      default: next_state = CLR_SCREEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLR_SCREEN;
      write_en  <= 1'b0;
      h_txt_out <= '0;
      v_txt_out <= '0;
      char_out  <= CHAR_SPACE;
      fg_q      <= '1;
      bg_q      <= '0;
      fg_out_q  <= '1;
      bg_out_q  <= '0;
    end else begin
      state    <= next_state;
      write_en <= wr_en;
      if (accept) begin
        fg_q <= fg_in;
        bg_q <= bg_in;
      end
      // Writes caused by an accept carry the colours sampled with that byte.
      if (wr_en) begin
        h_txt_out <= wr_col;
        v_txt_out <= wr_row;
        char_out  <= wr_char;
        fg_out_q  <= wr_from_in ? fg_in : fg_q;
        bg_out_q  <= wr_from_in ? bg_in : bg_q;
      end
    end
  end

endmodule
